flex_l4_parser: RTL and testbench
=================================

FLEX_L4_PARSER -- requirements
Module: flex_l4_parser

Interface
REQ-001 Parameter DATA_W, default 512: data beat width in bits; SHALL be 512 or 1024.
REQ-002 Parameter PADBYTES_W, default $clog2(DATA_W/8): width of the padbytes field.
REQ-003 Parameter HAS_ETH_HDR, default 1: 1 = beat 0 starts with an Ethernet header.
REQ-004 Parameter HAS_IP_HDR, default 1: 1 = an IPv4 header follows the Ethernet header, or starts the packet if HAS_ETH_HDR=0.
REQ-005 Parameter VLAN_EN, default 1: 1 = skip one 802.1Q tag (TPID 0x8100) when present; ignored if HAS_ETH_HDR=0.
REQ-006 Port clk, input, 1: sole clock; every register is clocked on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Ports src_parser_data_val in 1, src_parser_data in DATA_W, src_parser_padbytes in PADBYTES_W, src_parser_last in 1, parser_src_data_rdy out 1: input packet stream.
REQ-009 Ports parser_dst_meta_val out 1, parser_dst_hash_val out 1, parser_dst_hash_data out 96, parser_dst_l4_proto out 2, dst_parser_meta_rdy in 1: one metadata record per packet.
REQ-010 Ports parser_dst_data_val out 1, parser_dst_data out DATA_W, parser_dst_padbytes out PADBYTES_W, parser_dst_last out 1, dst_parser_data_rdy in 1: output packet stream.
REQ-011 parser_dst_hash_data SHALL be {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0]} (MSB first); parser_dst_l4_proto: 0 other, 1 TCP, 2 UDP.

Function
REQ-012 Byte 0 of a beat SHALL be data[DATA_W-1 -: 8]; multi-byte fields are big-endian; padbytes counts invalid bytes at the LSB end of a last beat.
REQ-013 A transfer SHALL occur on any edge where val and rdy are both high; val SHALL be independent of rdy.
REQ-014 The parser SHALL use states FIRST (next beat is beat 0 of a packet) and BODY; reset enters FIRST; FIRST->BODY on accepting a non-last beat; BODY->FIRST on accepting a last beat; FIRST->FIRST on accepting a single-beat packet.
REQ-015 Data output SHALL be a one-entry register slice: each accepted beat appears on the data output on the next cycle with data, padbytes and last unmodified (latency 1).
REQ-016 The data slot SHALL count as free when it is empty or dst_parser_data_rdy=1 in the same cycle.
REQ-017 In BODY, parser_src_data_rdy SHALL equal the data-slot-free condition.
REQ-018 In FIRST, parser_src_data_rdy SHALL additionally require the meta slot free (empty, or dst_parser_meta_rdy=1 in the same cycle).
REQ-019 On accepting beat 0, the parser SHALL load the meta slot, and parser_dst_meta_val SHALL rise in the same cycle as parser_dst_data_val for that beat.
REQ-020 parser_dst_meta_val SHALL then hold with stable fields until dst_parser_meta_rdy=1; meta and data slots drain independently.
REQ-021 L3 offset SHALL be 0 if HAS_ETH_HDR=0; otherwise 14, or 18 when VLAN_EN=1 and bytes 12-13 equal 0x8100 (ethertype then read at bytes 16-17).
REQ-022 IP checks: src_ip at L3+12, dst_ip at L3+16, protocol at L3+9; L4 offset is L3+20; src_port at L4+0, dst_port at L4+2.
REQ-023 parser_dst_hash_val SHALL be 1 only if all hold:
 - HAS_IP_HDR=1;
 - ethertype = 0x0800 (when HAS_ETH_HDR=1);
 - version = 4 and IHL = 5;
 - protocol is 6 or 17;
 - beat 0 valid bytes (DATA_W/8 - padbytes if last, else DATA_W/8) >= L4+4.
REQ-024 parser_dst_l4_proto SHALL be 1/2 for protocol 6/17 whenever HAS_IP_HDR=1, the ethertype check passes and beat 0 holds L3+10 valid bytes, else 0.
REQ-025 When parser_dst_hash_val=0, parser_dst_hash_data SHALL be all zeros.
REQ-026 Field extraction SHALL be combinational from beat 0 into the meta register; no extraction from later beats.

Reset
REQ-027 While rst is high, all val outputs, parser_src_data_rdy, parser_dst_hash_val and parser_dst_l4_proto SHALL be 0; state SHALL be FIRST; data, hash and padbytes registers SHALL be 0.
REQ-028 Reset asserted mid-packet SHALL discard both slots and the partial packet; after release, the next accepted beat is treated as beat 0.

Verification
REQ-029 Untagged TCP, 3 beats, 10.0.0.1:1234 -> 10.0.0.2:80, sinks always ready -> one meta record: hash_val=1, hash_data=0x0A000001_0A000002_04D2_0050, l4_proto=1; 3 data beats bit-identical, each 1 cycle after acceptance.
REQ-030 VLAN-tagged UDP (TPID 0x8100, ethertype 0x0800, proto 17, ports 53->5353), 1 beat, padbytes=10 -> hash_val=1, l4_proto=2, ports 0x0035/0x14E9.
REQ-031 ARP frame (ethertype 0x0806) -> meta_val=1 with hash_val=0, hash_data=0, l4_proto=0; data passes unchanged.
REQ-032 IPv4 with IHL=6 carrying TCP -> hash_val=0, l4_proto=1.
REQ-033 Two back-to-back 1-beat packets, dst_parser_meta_rdy held 0 for 5 cycles -> second beat 0 stalled (rdy=0) until first meta accepted, then accepted in the same cycle, with no meta loss.
REQ-034 rst pulsed during beat 2 of a 4-beat packet, then a new TCP packet -> all val outputs 0 during rst; new packet parsed correctly; no stale beats emitted.

Source files
------------

// File: rtl/flex_l4_parser.sv
// ============================================================================
// flex_l4_parser: one-beat register slice that emits an L3/L4 hash record per packet
// Rev 1.0
// ============================================================================
`default_nettype none

module flex_l4_parser #(
  parameter int DATA_W      = 512,
  parameter int PADBYTES_W  = $clog2(DATA_W/8),
  parameter bit HAS_ETH_HDR = 1'b1,
  parameter bit HAS_IP_HDR  = 1'b1,
  parameter bit VLAN_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_parser_data_val,
  input  logic [DATA_W-1:0]     src_parser_data,
  input  logic [PADBYTES_W-1:0] src_parser_padbytes,
  input  logic                  src_parser_last,
  output logic                  parser_src_data_rdy,
  output logic                  parser_dst_meta_val,
  output logic                  parser_dst_hash_val,
  output logic [95:0]           parser_dst_hash_data,
  output logic [1:0]            parser_dst_l4_proto,
  input  logic                  dst_parser_meta_rdy,
  output logic                  parser_dst_data_val,
  output logic [DATA_W-1:0]     parser_dst_data,
  output logic [PADBYTES_W-1:0] parser_dst_padbytes,
  output logic                  parser_dst_last,
  input  logic                  dst_parser_data_rdy
);

  localparam int BYTES = DATA_W/8;

  typedef enum logic [0:0] {FIRST = 1'b0, BODY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  dval_q;
  logic [DATA_W-1:0]     data_q;
  logic [PADBYTES_W-1:0] pad_q;
  logic                  last_q;
  logic                  mval_q;
  logic                  hval_q, hval_d;
  logic [95:0]           hash_q, hash_d;
  logic [1:0]            proto_q, proto_d;

  logic data_free, meta_free, src_rdy, accept;

  // Byte n of the beat counts from the MSB end.
  function automatic logic [7:0] hdr_byte(input logic [DATA_W-1:0] d, input logic [5:0] off);
    return d[DATA_W-1-8*int'(off) -: 8];
  endfunction

  assign data_free = !dval_q || dst_parser_data_rdy;
  assign meta_free = !mval_q || dst_parser_meta_rdy;
  assign accept    = src_parser_data_val && src_rdy;

  always_comb begin
    state_d = state_q;
    src_rdy = 1'b0;
    if (!rst) begin
      src_rdy = (state_q == FIRST) ? (data_free && meta_free) : data_free;
    end
    if (accept) begin
      state_d = src_parser_last ? FIRST : BODY;
    end
  end

  logic        is_vlan, eth_ok;
  logic [5:0]  l3;
  logic [15:0] etype, vbytes;
  logic [7:0]  ip_proto, ver_ihl;

  always_comb begin
    is_vlan  = HAS_ETH_HDR && VLAN_EN &&
               ({hdr_byte(src_parser_data, 6'd12), hdr_byte(src_parser_data, 6'd13)} == 16'h8100);
    l3       = !HAS_ETH_HDR ? 6'd0 : (is_vlan ? 6'd18 : 6'd14);
    etype    = is_vlan ? {hdr_byte(src_parser_data, 6'd16), hdr_byte(src_parser_data, 6'd17)}
                       : {hdr_byte(src_parser_data, 6'd12), hdr_byte(src_parser_data, 6'd13)};
    eth_ok   = !HAS_ETH_HDR || (etype == 16'h0800);
    vbytes   = src_parser_last ? (16'(BYTES) - 16'(src_parser_padbytes)) : 16'(BYTES);
    ver_ihl  = hdr_byte(src_parser_data, l3);
    ip_proto = hdr_byte(src_parser_data, l3 + 6'd9);

    proto_d = 2'd0;
    if (HAS_IP_HDR && eth_ok && (vbytes >= 16'(l3) + 16'd10)) begin
      if (ip_proto == 8'd6)       proto_d = 2'd1;
      else if (ip_proto == 8'd17) proto_d = 2'd2;
    end

    // Ports are read at L3+20, so only a 20-byte IP header (IHL=5) is hashable.
    hval_d = HAS_IP_HDR && eth_ok && (ver_ihl == 8'h45) &&
             ((ip_proto == 8'd6) || (ip_proto == 8'd17)) &&
             (vbytes >= 16'(l3) + 16'd24);
    hash_d = '0;
    if (hval_d) begin
      for (int i = 0; i < 12; i++) begin
        hash_d[95-8*i -: 8] = hdr_byte(src_parser_data, l3 + 6'd12 + 6'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FIRST;
      dval_q  <= 1'b0;
      data_q  <= '0;
      pad_q   <= '0;
      last_q  <= 1'b0;
      mval_q  <= 1'b0;
      hval_q  <= 1'b0;
      hash_q  <= '0;
      proto_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dval_q <= 1'b1;
        data_q <= src_parser_data;
        pad_q  <= src_parser_padbytes;
        last_q <= src_parser_last;
      end else if (dst_parser_data_rdy) begin
        dval_q <= 1'b0;
      end
      if (accept && (state_q == FIRST)) begin
        mval_q  <= 1'b1;
        hval_q  <= hval_d;
        hash_q  <= hash_d;
        proto_q <= proto_d;
      end else if (dst_parser_meta_rdy) begin
        mval_q <= 1'b0;
      end
    end
  end

  assign parser_src_data_rdy  = src_rdy;
  assign parser_dst_data_val  = dval_q;
  assign parser_dst_data      = data_q;
  assign parser_dst_padbytes  = pad_q;
  assign parser_dst_last      = last_q;
  assign parser_dst_meta_val  = mval_q;
  assign parser_dst_hash_val  = hval_q;
  assign parser_dst_hash_data = hash_q;
  assign parser_dst_l4_proto  = proto_q;

endmodule

`default_nettype wire

// File: tb/tb_flex_l4_parser.sv
// ============================================================================
// tb_flex_l4_parser: directed self-checking bench for flex_l4_parser (512-bit beats)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_flex_l4_parser;

  localparam int DW = 512;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_val = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic [PW-1:0] src_pad = '0;
  logic          src_last = 1'b0;
  logic          src_rdy;
  logic          meta_val, hash_val, meta_rdy = 1'b1;
  logic [95:0]   hash_data;
  logic [1:0]    l4_proto;
  logic          dval, dlast, data_rdy = 1'b1;
  logic [DW-1:0] ddata;
  logic [PW-1:0] dpad;

  flex_l4_parser dut (
    .clk(clk), .rst(rst),
    .src_parser_data_val(src_val), .src_parser_data(src_data),
    .src_parser_padbytes(src_pad), .src_parser_last(src_last),
    .parser_src_data_rdy(src_rdy),
    .parser_dst_meta_val(meta_val), .parser_dst_hash_val(hash_val),
    .parser_dst_hash_data(hash_data), .parser_dst_l4_proto(l4_proto),
    .dst_parser_meta_rdy(meta_rdy),
    .parser_dst_data_val(dval), .parser_dst_data(ddata),
    .parser_dst_padbytes(dpad), .parser_dst_last(dlast),
    .dst_parser_data_rdy(data_rdy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [PW-1:0] pad; logic last; int cyc; } dbeat_t;
  typedef struct { logic hv; logic [95:0] h; logic [1:0] p; int cyc; } meta_t;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     accq[$];
  dbeat_t dq[$];
  meta_t  mq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (src_val && src_rdy) accq.push_back(cyc);
      if (dval && data_rdy) dq.push_back('{ddata, dpad, dlast, cyc});
      if (meta_val && meta_rdy) mq.push_back('{hash_val, hash_data, l4_proto, cyc});
    end
  end

  function automatic logic [DW-1:0] mk_beat(input bit vlan, input logic [15:0] etype,
      input logic [7:0] verihl, input logic [7:0] proto, input logic [31:0] sip,
      input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp);
    logic [7:0]    b [64];
    logic [DW-1:0] r;
    int            l3;
    for (int i = 0; i < 64; i++) b[i] = 8'(i * 7 + 3);
    l3 = 14;
    if (vlan) begin
      b[12] = 8'h81; b[13] = 8'h00; b[14] = 8'h00; b[15] = 8'h64;
      l3 = 18;
    end
    b[l3-2] = etype[15:8]; b[l3-1] = etype[7:0];
    b[l3] = verihl; b[l3+9] = proto;
    for (int i = 0; i < 4; i++) begin
      b[l3+12+i] = sip[31-8*i -: 8];
      b[l3+16+i] = dip[31-8*i -: 8];
    end
    b[l3+20] = sp[15:8]; b[l3+21] = sp[7:0];
    b[l3+22] = dp[15:8]; b[l3+23] = dp[7:0];
    for (int i = 0; i < 64; i++) r[DW-1-8*i -: 8] = b[i];
    return r;
  endfunction

  task automatic clear_q();
    accq.delete(); dq.delete(); mq.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] pad, input logic last);
    int n;
    src_data = d; src_pad = pad; src_last = last; src_val = 1'b1;
    n = 0;
    @(negedge clk);
    while (!src_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!src_rdy) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout rdy=%b after %0d cycles, required 1", src_rdy, n);
    end
    @(posedge clk); #1;
    src_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_val = 1'b1; src_data = '1; src_last = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({dval, meta_val, src_rdy, hash_val, l4_proto} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got dval/mval/rdy/hval/proto=%b%b%b%b%b required all 0",
               dval, meta_val, src_rdy, hash_val, l4_proto);
    end
    n_cmp++;
    if (ddata !== '0 || hash_data !== 96'h0 || dpad !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got data=%h hash=%h pad=%0d required 0", ddata, hash_data, dpad);
    end
    src_val = 1'b0; src_last = 1'b0;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_tcp_3beat();
    logic [DW-1:0] b[3];
    logic [PW-1:0] p[3];
    clear_q();
    b[0] = mk_beat(0, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    b[1] = {16{32'hDEADBEEF}};
    b[2] = {16{32'h01234567}};
    p[0] = 6'd0; p[1] = 6'd0; p[2] = 6'd5;
    for (int i = 0; i < 3; i++) send(b[i], p[i], i == 2);
    idle(4);
    n_cmp++;
    if (mq.size() != 1) begin
      n_fail++; $display("FAIL tcp_meta_count got %0d required 1", mq.size());
    end else begin
      n_cmp++;
      if (mq[0].hv !== 1'b1 || mq[0].h !== 96'h0A000001_0A000002_04D2_0050 || mq[0].p !== 2'd1) begin
        n_fail++;
        $display("FAIL tcp_meta got hv=%b h=%h p=%0d required hv=1 h=0a0000010a00000204d20050 p=1",
                 mq[0].hv, mq[0].h, mq[0].p);
      end
    end
    n_cmp++;
    if (dq.size() != 3 || accq.size() != 3) begin
      n_fail++;
      $display("FAIL tcp_beat_count got data=%0d acc=%0d required 3/3", dq.size(), accq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (dq[i].d !== b[i] || dq[i].pad !== p[i] || dq[i].last !== (i == 2)) begin
          n_fail++;
          $display("FAIL tcp_beat%0d got pad=%0d last=%b data=%h required pad=%0d", i,
                   dq[i].pad, dq[i].last, dq[i].d[DW-1 -: 64], p[i]);
        end
        n_cmp++;
        if (dq[i].cyc !== accq[i] + 1) begin
          n_fail++;
          $display("FAIL tcp_latency%0d got out cycle %0d required %0d", i, dq[i].cyc, accq[i] + 1);
        end
      end
      if (mq.size() == 1) begin
        n_cmp++;
        if (mq[0].cyc !== dq[0].cyc) begin
          n_fail++;
          $display("FAIL tcp_meta_align got meta cycle %0d required %0d", mq[0].cyc, dq[0].cyc);
        end
      end
    end
  endtask

  // Single-beat packet; checks meta fields and that the beat passes through.
  task automatic one_beat(input string nm, input logic [DW-1:0] b, input logic [PW-1:0] pad,
                          input logic xhv, input logic [95:0] xh, input logic [1:0] xp);
    clear_q();
    send(b, pad, 1'b1);
    idle(3);
    n_cmp++;
    if (mq.size() != 1) begin
      n_fail++; $display("FAIL %s_meta_count got %0d required 1", nm, mq.size());
    end else if (mq[0].hv !== xhv || mq[0].h !== xh || mq[0].p !== xp) begin
      n_fail++;
      $display("FAIL %s_meta got hv=%b h=%h p=%0d required hv=%b h=%h p=%0d",
               nm, mq[0].hv, mq[0].h, mq[0].p, xhv, xh, xp);
    end
    n_cmp++;
    if (dq.size() != 1) begin
      n_fail++; $display("FAIL %s_data_count got %0d required 1", nm, dq.size());
    end else if (dq[0].d !== b || dq[0].pad !== pad || dq[0].last !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_data got pad=%0d last=%b required pad=%0d last=1", nm, dq[0].pad, dq[0].last, pad);
    end
  endtask

  task automatic test_vlan_udp();
    one_beat("vlan_udp",
             mk_beat(1, 16'h0800, 8'h45, 8'd17, 32'hC0A8010A, 32'h08080808, 16'd53, 16'd5353),
             6'd10, 1'b1, 96'hC0A8010A_08080808_0035_14E9, 2'd2);
  endtask

  task automatic test_arp();
    one_beat("arp", mk_beat(0, 16'h0806, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1, 16'd2),
             6'd0, 1'b0, 96'h0, 2'd0);
  endtask

  task automatic test_ihl6();
    one_beat("ihl6", mk_beat(0, 16'h0800, 8'h46, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80),
             6'd0, 1'b0, 96'h0, 2'd1);
  endtask

  task automatic test_short_beat();
    // 37 valid bytes is one short of L4+4 (38); 38 is exactly enough.
    one_beat("short37", mk_beat(0, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80),
             6'd27, 1'b0, 96'h0, 2'd1);
    one_beat("short38", mk_beat(0, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80),
             6'd26, 1'b1, 96'h0A000001_0A000002_04D2_0050, 2'd1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    int            n;
    clear_q();
    a = mk_beat(0, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1000, 16'd2000);
    b = mk_beat(0, 16'h0800, 8'h45, 8'd17, 32'h0A000003, 32'h0A000004, 16'd7, 16'd9);
    meta_rdy = 1'b0;
    send(a, 6'd0, 1'b1);
    src_data = b; src_pad = 6'd0; src_last = 1'b1; src_val = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (src_rdy !== 1'b0) n++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n != 0) begin
      n_fail++; $display("FAIL b2b_stall got rdy high on %0d of 5 cycles required 0", n);
    end
    meta_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (src_rdy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_release got rdy=%b required 1", src_rdy);
    end
    @(posedge clk); #1;
    src_val = 1'b0;
    idle(3);
    n_cmp++;
    if (mq.size() != 2 || accq.size() != 2) begin
      n_fail++; $display("FAIL b2b_count got meta=%0d acc=%0d required 2/2", mq.size(), accq.size());
    end else begin
      n_cmp++;
      if (mq[0].h !== 96'h0A000001_0A000002_03E8_07D0 || mq[0].p !== 2'd1 ||
          mq[1].h !== 96'h0A000003_0A000004_0007_0009 || mq[1].p !== 2'd2) begin
        n_fail++;
        $display("FAIL b2b_meta got h0=%h p0=%0d h1=%h p1=%0d required 0a0000010a00000203e807d0/1 0a0000030a00000400070009/2",
                 mq[0].h, mq[0].p, mq[1].h, mq[1].p);
      end
      n_cmp++;
      if (accq[1] !== mq[0].cyc) begin
        n_fail++;
        $display("FAIL b2b_same_cycle got accept cycle %0d required meta accept cycle %0d", accq[1], mq[0].cyc);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [DW-1:0] n0, n1;
    clear_q();
    send(mk_beat(0, 16'h0800, 8'h45, 8'd6, 32'h01020304, 32'h05060708, 16'd11, 16'd22), 6'd0, 1'b0);
    send({16{32'hAAAA5555}}, 6'd0, 1'b0);
    src_data = {16{32'hBBBB6666}}; src_pad = 6'd0; src_last = 1'b0; src_val = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dval, meta_val, src_rdy, hash_val, l4_proto} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs got dval/mval/rdy/hval/proto=%b%b%b%b%b required all 0",
               dval, meta_val, src_rdy, hash_val, l4_proto);
    end
    @(negedge clk);
    src_val = 1'b0;
    rst = 1'b0;
    idle(1);
    clear_q();
    n0 = mk_beat(0, 16'h0800, 8'h45, 8'd6, 32'hAC100001, 32'hAC100002, 16'd443, 16'd8080);
    n1 = {16{32'hCAFEF00D}};
    send(n0, 6'd0, 1'b0);
    send(n1, 6'd3, 1'b1);
    idle(4);
    n_cmp++;
    if (mq.size() != 1) begin
      n_fail++; $display("FAIL midrst_meta_count got %0d required 1", mq.size());
    end else if (mq[0].hv !== 1'b1 || mq[0].h !== 96'hAC100001_AC100002_01BB_1F90 || mq[0].p !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_meta got hv=%b h=%h p=%0d required hv=1 h=ac100001ac10000201bb1f90 p=1",
               mq[0].hv, mq[0].h, mq[0].p);
    end
    n_cmp++;
    if (dq.size() != 2) begin
      n_fail++; $display("FAIL midrst_data_count got %0d required 2", dq.size());
    end else if (dq[0].d !== n0 || dq[1].d !== n1 || dq[1].pad !== 6'd3 || dq[1].last !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_data got beat1 pad=%0d last=%b required pad=3 last=1", dq[1].pad, dq[1].last);
    end
  endtask

  initial begin
    test_reset();
    test_tcp_3beat();
    test_vlan_udp();
    test_arp();
    test_ihl6();
    test_short_beat();
    test_back_to_back();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
